// File: rtl/alu_instr_sequencer_if.sv
// Instruction handshake between an instruction source and alu_instr_sequencer.
interface alu_instr_sequencer_if;
   localparam int unsigned INSTR_W = 12;

   logic               in_valid;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle instruction sequencer driving the 4-bit register-file/ALU datapath
// controls; captures ALU carry-out and counts retired instructions.
module alu_instr_sequencer (
   input  logic                 clk,
   input  logic                 reset,
   alu_instr_sequencer_if.slave in_if,
   output logic [1:0]           dp_rd1,
   output logic [1:0]           dp_rd2,
   output logic [1:0]           dp_wr,
   output logic [2:0]           dp_oper,
   output logic [3:0]           dp_data,
   output logic                 dp_src_alu,
   output logic                 dp_wstrobe,
   input  logic                 dp_carry,
   output logic                 carry_flag,
   output logic                 done,
   output logic                 halted,
   output logic [7:0]           instr_count
);
   localparam int unsigned KIND_W  = 2;
   localparam int unsigned COUNT_W = 8;

   localparam logic [KIND_W-1:0] K_NOP   = 2'b00;
   localparam logic [KIND_W-1:0] K_LOADI = 2'b01;
   localparam logic [KIND_W-1:0] K_ALU   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t            state;
   logic [KIND_W-1:0] kind_q;
   logic              ready_q;

   assign in_if.in_ready = ready_q;

   // Datapath controls load on the handshake edge and hold until the next one;
   // only the kind field needs to live on for sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         kind_q      <= '0;
         ready_q     <= 1'b1;
         dp_rd1      <= '0;
         dp_rd2      <= '0;
         dp_wr       <= '0;
         dp_oper     <= '0;
         dp_data     <= '0;
         dp_src_alu  <= 1'b0;
         dp_wstrobe  <= 1'b0;
         carry_flag  <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         done       <= 1'b0;
         dp_wstrobe <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (in_if.in_valid) begin
                  kind_q     <= in_if.in_instr[11:10];
                  dp_oper    <= in_if.in_instr[9:7];
                  dp_wr      <= in_if.in_instr[6:5];
                  dp_rd1     <= in_if.in_instr[4:3];
                  dp_rd2     <= in_if.in_instr[2:1];
                  dp_data    <= in_if.in_instr[3:0];
                  dp_src_alu <= (in_if.in_instr[11:10] == K_ALU);
                  ready_q    <= 1'b0;
                  state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               unique case (kind_q)
                  K_NOP: begin
                     done        <= 1'b1;
                     instr_count <= instr_count + COUNT_W'(1);
                     ready_q     <= 1'b1;
                     state       <= S_IDLE;
                  end
                  K_LOADI: begin
                     dp_wstrobe <= 1'b1;
                     state      <= S_WB;
                  end
                  K_ALU: begin
                     state <= S_READ;
                  end
                  default: begin
                     done        <= 1'b1;
                     instr_count <= instr_count + COUNT_W'(1);
                     halted      <= 1'b1;
                     state       <= S_HALT;
                  end
               endcase
            end
            S_READ: begin
               state <= S_EXEC;
            end
            S_EXEC: begin
               dp_wstrobe <= 1'b1;
               state      <= S_WB;
            end
            // Strobe is high during this state; carry is sampled as it closes.
            S_WB: begin
               if (kind_q == K_ALU) carry_flag <= dp_carry;
               done        <= 1'b1;
               instr_count <= instr_count + COUNT_W'(1);
               ready_q     <= 1'b1;
               state       <= S_IDLE;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
